// File: rtl/axi_rd_arb2.sv
// rtl/axi_rd_arb2.sv - two-master round-robin AXI read arbiter, one transaction in flight
module axi_rd_arb2 #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    localparam int AR_W      = ID_WIDTH + ADDR_WIDTH + 13,
    localparam int R_W       = ID_WIDTH + DATA_WIDTH + 3
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [AR_W-1:0] m0_ar,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [R_W-1:0]  m0_r,
    output logic            m0_rvalid,
    input  logic            m0_rready,

    input  logic [AR_W-1:0] m1_ar,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [R_W-1:0]  m1_r,
    output logic            m1_rvalid,
    input  logic            m1_rready,

    output logic [AR_W-1:0] s_ar,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [R_W-1:0]  s_r,
    input  logic            s_rvalid,
    output logic            s_rready,

    output logic            grant,
    output logic            busy,
    output logic            len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       grant_q;
    logic       last_grant_q;
    logic [7:0] cnt_q;
    logic       len_err_q;

    logic       arb_pick;
    logic       any_req;
    logic       ar_hs;
    logic       r_hs;
    logic       r_last;
    logic [7:0] sel_len;

    // Round-robin pick: on a tie the master that was not served last wins.
    always_comb begin
        any_req  = m0_arvalid | m1_arvalid;
        arb_pick = m1_arvalid & (~m0_arvalid | ~last_grant_q);
    end

    // State register; reset aborts any outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel steering; everything not owned by the granted master is held at 0.
    always_comb begin
        state_nxt  = state;
        s_ar       = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_r       = '0;
        m0_rvalid  = 1'b0;
        m1_r       = '0;
        m1_rvalid  = 1'b0;
        ar_hs      = 1'b0;
        r_hs       = 1'b0;
        r_last     = 1'b0;
        sel_len    = 8'd0;

        case (state)
            IDLE: begin
                // Arbitration only; no address handshake can happen here.
                if (any_req) begin
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                if (grant_q) begin
                    s_ar       = m1_ar;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                    ar_hs      = m1_arvalid & s_arready;
                    sel_len    = m1_ar[12:5];
                end else begin
                    s_ar       = m0_ar;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                    ar_hs      = m0_arvalid & s_arready;
                    sel_len    = m0_ar[12:5];
                end
                // A granted master that withdraws arvalid simply parks us here.
                if (ar_hs) begin
                    state_nxt = DATA;
                end
            end

            DATA: begin
                if (grant_q) begin
                    m1_r      = s_r;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                    r_hs      = s_rvalid & m1_rready;
                end else begin
                    m0_r      = s_r;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                    r_hs      = s_rvalid & m0_rready;
                end
                r_last = s_r[0];
                // Only the slave's last flag ends the burst, even if the count disagrees.
                if (r_hs && r_last) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, round-robin history, beat counter and sticky length error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_q <= arb_pick;
            end
            if (ar_hs) begin
                cnt_q <= sel_len;
            end
            if (r_hs) begin
                if (cnt_q != 8'd0) begin
                    cnt_q <= cnt_q - 8'd1;
                end
                if ((r_last && cnt_q != 8'd0) || (!r_last && cnt_q == 8'd0)) begin
                    len_err_q <= 1'b1;
                end
                if (r_last) begin
                    last_grant_q <= grant_q;
                end
            end
        end
    end

    // Status outputs.
    always_comb begin
        grant   = grant_q;
        busy    = (state != IDLE);
        len_err = len_err_q;
    end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// tb/tb_axi_rd_arb2.sv - directed self-checking bench for axi_rd_arb2
module tb_axi_rd_arb2;

    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int ID_WIDTH   = 4;
    localparam int AR_W       = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int R_W        = ID_WIDTH + DATA_WIDTH + 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AR_W-1:0] m0_ar, m1_ar, s_ar;
    logic            m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [R_W-1:0]  m0_r, m1_r, s_r;
    logic            m0_rvalid, m0_rready, m1_rvalid, m1_rready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic            grant, busy, len_err;

    int vectors    = 0;
    int miscompares = 0;
    int beat_cnt   = 0;

    axi_rd_arb2 #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_ar      (m0_ar),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_r       (m0_r),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_ar      (m1_ar),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_r       (m1_r),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_ar       (s_ar),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_r        (s_r),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .grant      (grant),
        .busy       (busy),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [AR_W-1:0] mk_ar(input logic [ID_WIDTH-1:0] id,
                                              input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [7:0] len);
        return {id, addr, len, 3'd3, 2'b01};
    endfunction

    function automatic logic [R_W-1:0] mk_r(input logic [ID_WIDTH-1:0] id,
                                            input logic [DATA_WIDTH-1:0] data,
                                            input logic last);
        return {id, data, 2'b00, last};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called with the FSM in IDLE; leaves it in DATA after the address handshake.
    task automatic addr_phase(input int m, input logic [AR_W-1:0] ar, input bit drop);
        if (m == 0) begin m0_ar = ar; m0_arvalid = 1'b1; end
        else        begin m1_ar = ar; m1_arvalid = 1'b1; end
        tick;
        chk("grant", 128'(grant), 128'(m));
        chk("busy_addr", 128'(busy), 128'(1));
        chk("s_arvalid", 128'(s_arvalid), 128'(1));
        chk("s_ar", 128'(s_ar), 128'(ar));
        chk("arready_granted", 128'(m == 0 ? m0_arready : m1_arready), 128'(1));
        chk("arready_other", 128'(m == 0 ? m1_arready : m0_arready), 128'(0));
        tick;
        if (drop) begin
            if (m == 0) begin m0_arvalid = 1'b0; m0_ar = '0; end
            else        begin m1_arvalid = 1'b0; m1_ar = '0; end
        end
    endtask

    // Drives n slave beats, flagging last on beat last_at (0 = never).
    task automatic beats(input int m, input int n, input int last_at, input logic [63:0] seed);
        logic [R_W-1:0] rv;
        for (int i = 1; i <= n; i++) begin
            rv = mk_r(4'(m + 1), seed + 64'(i), (i == last_at));
            s_r = rv;
            s_rvalid = 1'b1;
            #1;
            if (m == 0) begin
                chk("m0_rvalid", 128'(m0_rvalid), 128'(1));
                chk("m0_r", 128'(m0_r), 128'(rv));
                chk("m1_rvalid_idle", 128'(m1_rvalid), 128'(0));
                chk("m1_r_zero", 128'(m1_r), 128'(0));
                if (m0_rvalid && m0_rready) beat_cnt++;
            end else begin
                chk("m1_rvalid", 128'(m1_rvalid), 128'(1));
                chk("m1_r", 128'(m1_r), 128'(rv));
                chk("m0_rvalid_idle", 128'(m0_rvalid), 128'(0));
                chk("m0_r_zero", 128'(m0_r), 128'(0));
                if (m1_rvalid && m1_rready) beat_cnt++;
            end
            chk("s_rready", 128'(s_rready), 128'(1));
            chk("busy_data", 128'(busy), 128'(1));
            tick;
        end
        s_rvalid = 1'b0;
        s_r = '0;
    endtask

    initial begin
        logic [R_W-1:0]  rv;
        logic [AR_W-1:0] a0, a1;

        rst_n = 1'b0;
        m0_ar = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_ar = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b1; s_r = '0; s_rvalid = 1'b0;
        tick; tick;

        // Reset state
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_len_err", 128'(len_err), 128'(0));
        chk("rst_s_arvalid", 128'(s_arvalid), 128'(0));
        chk("rst_s_ar", 128'(s_ar), 128'(0));
        chk("rst_m0_arready", 128'(m0_arready), 128'(0));
        chk("rst_m1_rvalid", 128'(m1_rvalid), 128'(0));
        rst_n = 1'b1;
        tick;

        // Simultaneous requests after reset: m0 first, then m1, addresses unchanged
        a0 = mk_ar(4'h1, 64'h0000_1000_0000_0040, 8'd0);
        a1 = mk_ar(4'h2, 64'hFFFF_0000_1234_5678, 8'd0);
        m1_ar = a1; m1_arvalid = 1'b1;
        m0_ar = a0; m0_arvalid = 1'b1;
        #1;
        chk("idle_no_hs_m0", 128'(m0_arready), 128'(0));
        chk("idle_no_hs_m1", 128'(m1_arready), 128'(0));
        addr_phase(0, a0, 1);
        beats(0, 1, 1, 64'hA000);
        chk("t1_idle_busy", 128'(busy), 128'(0));
        addr_phase(1, a1, 1);
        beats(1, 1, 1, 64'hB000);

        // m1 len=3 burst, four beats
        beat_cnt = 0;
        addr_phase(1, mk_ar(4'h3, 64'h2000, 8'd3), 1);
        beats(1, 4, 4, 64'hC000);
        chk("t2_beats", 128'(beat_cnt), 128'(4));
        chk("t2_busy_fall", 128'(busy), 128'(0));
        chk("t2_len_err", 128'(len_err), 128'(0));

        // m0 holds arvalid; m1 requests once: m0, m1, m0
        a0 = mk_ar(4'h4, 64'h3000, 8'd0);
        a1 = mk_ar(4'h5, 64'h4000, 8'd0);
        m1_ar = a1; m1_arvalid = 1'b1;
        addr_phase(0, a0, 0);
        chk("t3_wait_m0_arready", 128'(m0_arready), 128'(0));
        chk("t3_wait_m1_arready", 128'(m1_arready), 128'(0));
        beats(0, 1, 1, 64'hD000);
        addr_phase(1, a1, 1);
        beats(1, 1, 1, 64'hD100);
        addr_phase(0, a0, 1);
        beats(0, 1, 1, 64'hD200);

        // m0_rready stalls 5 cycles during DATA
        addr_phase(0, mk_ar(4'h6, 64'h5000, 8'd1), 1);
        m0_rready = 1'b0;
        rv = mk_r(4'h1, 64'hE001, 1'b0);
        s_r = rv; s_rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_s_rready", 128'(s_rready), 128'(0));
            chk("stall_m0_r", 128'(m0_r), 128'(rv));
            tick;
        end
        m0_rready = 1'b1;
        #1;
        chk("unstall_s_rready", 128'(s_rready), 128'(1));
        chk("unstall_m0_r", 128'(m0_r), 128'(rv));
        tick;
        rv = mk_r(4'h1, 64'hE002, 1'b1);
        s_r = rv;
        #1;
        chk("stall_beat2_m0_r", 128'(m0_r), 128'(rv));
        chk("stall_busy_beat2", 128'(busy), 128'(1));
        tick;
        s_rvalid = 1'b0; s_r = '0;
        chk("stall_done_busy", 128'(busy), 128'(0));
        chk("stall_len_err", 128'(len_err), 128'(0));

        // Early last on beat 2 of a len=3 burst; error is sticky
        addr_phase(0, mk_ar(4'h7, 64'h6000, 8'd3), 1);
        beats(0, 2, 2, 64'hF000);
        chk("early_last_err", 128'(len_err), 128'(1));
        chk("early_last_idle", 128'(busy), 128'(0));
        addr_phase(1, mk_ar(4'h8, 64'h7000, 8'd0), 1);
        beats(1, 1, 1, 64'hF100);
        chk("sticky_err_1", 128'(len_err), 128'(1));
        addr_phase(0, mk_ar(4'h9, 64'h8000, 8'd0), 1);
        beats(0, 1, 1, 64'hF200);
        chk("sticky_err_2", 128'(len_err), 128'(1));

        // Reset during beat 2 of an m1 burst after m0 was served last
        addr_phase(1, mk_ar(4'hA, 64'h9000, 8'd3), 1);
        beats(1, 1, 0, 64'h9900);
        s_r = mk_r(4'h2, 64'h9902, 1'b0); s_rvalid = 1'b1;
        #1;
        chk("pre_rst_m1_rvalid", 128'(m1_rvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 128'(grant), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_len_err", 128'(len_err), 128'(0));
        chk("arst_m1_rvalid", 128'(m1_rvalid), 128'(0));
        chk("arst_m1_r", 128'(m1_r), 128'(0));
        chk("arst_s_rready", 128'(s_rready), 128'(0));
        chk("arst_s_arvalid", 128'(s_arvalid), 128'(0));
        s_rvalid = 1'b0; s_r = '0;
        tick;
        rst_n = 1'b1;
        a0 = mk_ar(4'hB, 64'hA000, 8'd0);
        a1 = mk_ar(4'hC, 64'hB000, 8'd0);
        m1_ar = a1; m1_arvalid = 1'b1;
        addr_phase(0, a0, 1);
        beats(0, 1, 1, 64'hAA00);
        chk("post_rst_len_err", 128'(len_err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
